// File: rtl/sw_debounce_pkg.sv
// ============================================================================
// sw_debounce_pkg : shared types and constants for the switch debouncer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sw_debounce_pkg;

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    localparam int DEF_STABLE_CYCLES = 100000;
    localparam int SIM_STABLE_CYCLES = 4;

endpackage : sw_debounce_pkg

`default_nettype wire

// File: rtl/sw_debounce_db_bit.sv
// ============================================================================
// db_bit : single-bit two-flop synchroniser, saturating counter and debounce FSM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module db_bit
    import sw_debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_q,
    output logic o_chg,
    output logic o_flip
);

    localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_q;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt;
    db_state_e        r_state;

    logic w_diff;
    logic w_flip;

    assign w_diff = r_sync2 ^ r_q;
    // Flip only once the run of differing samples has reached STABLE_CYCLES+1
    assign w_flip = (r_state == ST_PENDING) && w_diff && (r_cnt == C_CNT_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
            r_q     <= RST_VAL;
            r_chg   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_STABLE;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
            r_chg   <= w_flip;
            case (r_state)
                ST_STABLE: begin
                    if (w_diff) begin
                        r_state <= ST_PENDING;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                ST_PENDING: begin
                    if (!w_diff || w_flip) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                        if (w_flip) begin
                            r_q <= ~r_q;
                        end
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_q    = r_q;
    assign o_chg  = r_chg;
    assign o_flip = w_flip;

endmodule : db_bit

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// sw_debounce : WIDTH-bit switch synchroniser/debouncer with change pulses.
// Optional rise/fall pulse decode enabled by SW_DEBOUNCE_EDGE_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_chg,
    output logic             any_chg,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_chg;
    logic [WIDTH-1:0] w_flip;
    logic             r_any;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        db_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RST_VAL       (RST_VAL[gi])
        ) u_db_bit (
            .clk    (clk),
            .rstn   (rstn),
            .i_d    (sw_raw[gi]),
            .o_q    (w_q[gi]),
            .o_chg  (w_chg[gi]),
            .o_flip (w_flip[gi])
        );
    end

    // Reduce the pre-register flip vector so any_chg lands with sw_chg
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_flip;
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_flip & ~w_q;
            r_fall <= w_flip &  w_q;
        end
    end

    assign sw_rise = r_rise;
    assign sw_fall = r_fall;
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif

    assign sw_db   = w_q;
    assign sw_chg  = w_chg;
    assign any_chg = r_any;

endmodule : sw_debounce

`default_nettype wire

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the lab top-level switch-to-LED logic. It takes the raw `sw[7:0]` board switches and drives the clean `sw` bus that logic consumes.
- Each bit is synchronised into the clock domain and debounced.
- A registered bus is produced, plus per-bit change pulses, so downstream logic never sees metastable or bouncing switch values.

Parameters:
- WIDTH, 8: number of switch bits handled.
- STABLE_CYCLES, 100000: consecutive cycles a synchronised bit must differ from its debounced value before the output flips. This is 1 ms at 100 MHz. Legal range is ≥ 1.
- RST_VAL, 8'h00: value loaded into `sw_db` on reset (WIDTH bits).
- CNT_W (localparam), $clog2(STABLE_CYCLES+1): width of the per-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- sw_raw  in  WIDTH  raw asynchronous switch inputs.
- sw_db  out  WIDTH  debounced, registered switch value; feeds the top-level `sw`.
- sw_chg  out  WIDTH  one-cycle pulse per bit, high in the cycle `sw_db[i]` has just flipped.
- any_chg  out  1  OR-reduction of `sw_chg`, registered together with it.
- sw_rise  out  WIDTH  one-cycle rising-edge pulse per bit (feature-dependent).
- sw_fall  out  WIDTH  one-cycle falling-edge pulse per bit (feature-dependent).

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low on rstn.
  - While rstn=0, all of the following are held: `sw_db=RST_VAL`, sync flops = RST_VAL, counters = 0, `sw_chg`/`any_chg`/`sw_rise`/`sw_fall` = 0, every bit FSM in STABLE.
  - Reset asserted mid-count discards the pending change.
- Synchroniser: two flops per bit, `sync1 <= sw_raw`, `sync2 <= sync1`. The FSM acts only on `sync2`.
- Per-bit FSM, states STABLE and PENDING:
  - STABLE: if `sync2 == sw_db`, hold with cnt=0. Otherwise go to PENDING with cnt=1.
  - PENDING, `sync2 == sw_db` (bounce back): go to STABLE, cnt=0, no pulse.
  - PENDING, `sync2 != sw_db` and `cnt == STABLE_CYCLES`: flip `sw_db`, pulse `sw_chg`, go to STABLE, cnt=0.
  - PENDING, otherwise: cnt+1.
  - With STABLE_CYCLES=1, the flip happens on the cycle after entering PENDING.
- Latency: a raw change held steadily appears on `sw_db` exactly `2+STABLE_CYCLES+1` rising edges after the first sampling edge. With STABLE_CYCLES=4 that is 7 edges.
- Glitch rejection: a `sync2` excursion lasting ≤ STABLE_CYCLES cycles never changes `sw_db`.
- Pulse timing: `sw_chg[i]` is high for exactly the one cycle in which the new `sw_db[i]` is first visible. `any_chg` is aligned with it.
- Independence and saturation:
  - Bits are fully independent; several bits may flip in the same cycle, with multiple `sw_chg` bits set.
  - The counter cannot wrap: it is cleared on flip or bounce and never exceeds STABLE_CYCLES.

Optional Feature:
- Macro: SW_DEBOUNCE_EDGE_EN.
- Defined:
  - `sw_rise[i] = sw_chg[i] & sw_db[i]`.
  - `sw_fall[i] = sw_chg[i] & ~sw_db[i]`.
  - Both are registered-aligned with `sw_chg`.
- Undefined: `sw_rise` and `sw_fall` are tied to 0 and no extra logic is generated. The port list is unchanged.

Decomposition:
- Package `sw_debounce_pkg` holds:
  - the per-bit state enum (STABLE, PENDING);
  - `DEF_STABLE_CYCLES = 100000`;
  - `SIM_STABLE_CYCLES = 4`.
- Sub-module `db_bit`: a single-bit synchroniser + counter + FSM with outputs `q` and `chg`. It is instantiated WIDTH times in a generate loop. The top level does the `any_chg` reduction and the edge decode.

Test Plan (STABLE_CYCLES=4, RST_VAL=0, SW_DEBOUNCE_EDGE_EN defined):
1. Reset and clean rise:
   - Stimulus: rstn low for 3 cycles, release, then `sw_raw=8'h01` held.
   - Required: `sw_db=8'h00` throughout reset. `sw_db` becomes `8'h01` on edge 7. `sw_chg=8'h01`, `any_chg=1` and `sw_rise=8'h01` for that one cycle only.
2. Glitch rejection:
   - Stimulus: from `sw_db=8'h01`, drive `sw_raw=8'h03` for 3 cycles, then back to `8'h01`.
   - Required: `sw_db` stays `8'h01`; no `sw_chg` pulse.
3. Bounce then settle:
   - Stimulus: toggle `sw_raw[7]` every 2 cycles 4 times, then hold 1.
   - Required: `sw_db` goes from `8'h01` to `8'h81` exactly 7 edges after the final stable level is sampled. One `sw_chg` pulse.
4. Simultaneous multi-bit change:
   - Stimulus: `sw_raw` from `8'h81` to `8'h80` and bit 1 to 1 (`8'h82`) in the same cycle.
   - Required: both bits flip on the same edge. `sw_chg=8'h03`, `sw_rise=8'h02`, `sw_fall=8'h01`.
5. Reset mid-operation:
   - Stimulus: change `sw_raw` to `8'hFF`, assert rstn at cycle 4 (before the flip), release.
   - Required:
     - `sw_db` is immediately `8'h00`, asynchronously.
     - After release, with `sw_raw` still `8'hFF`, `sw_db=8'hFF` 7 edges later.
     - No pulse is seen during reset.
